// File: rtl/barrett_mu_gen_if.sv
// Request/response bundle between a modulus selector and barrett_mu_gen.
// Latency: none (wires only).
// Backpressure: none. start is a request that the generator samples only while idle.
// Ports:
//   start/Q                      request toward the generator
//   busy/done/err/mu_out/q_out   status and result back to the requester
// master modport = requester, slave modport = barrett_mu_gen.
interface barrett_mu_gen_if #(
  parameter int Q_WIDTH  = 23,
  parameter int MU_WIDTH = 47
);
  logic                start;
  logic [Q_WIDTH-1:0]  Q;
  logic                busy;
  logic                done;
  logic                err;
  logic [MU_WIDTH-1:0] mu_out;
  logic [Q_WIDTH-1:0]  q_out;

  modport master (output start, Q, input busy, done, err, mu_out, q_out);
  modport slave  (input start, Q, output busy, done, err, mu_out, q_out);
endinterface

// File: rtl/barrett_mu_gen.sv
// Barrett constant generator: mu = floor(2^K / Q) by restoring division, one quotient bit per clock.
// Latency: done rises K+2 edges after the accepting edge. Q==0 (and a cache hit) takes the accept edge plus one FIN edge.
// Backpressure: start is honoured only in IDLE. A start in DIV/FIN is dropped, not queued.
// Ports:
//   clk, rst  rising-edge clock and asynchronous active-high reset
//   bus       slave side of barrett_mu_gen_if (start/Q in; busy/done/err/mu_out/q_out out)
// Optional feature: define BARRETT_MU_CACHE_EN to reuse the last good mu when the same Q is requested again.
module barrett_mu_gen #(
  parameter int Q_WIDTH  = 23,
  parameter int K        = 2*Q_WIDTH,
  parameter int MU_WIDTH = K+1
) (
  input  logic            clk,
  input  logic            rst,
  barrett_mu_gen_if.slave bus
);
  localparam int CNT_W = $clog2(K+1);

  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_FIN} state_t;

  state_t              r_state;
  logic [Q_WIDTH-1:0]  r_q;
  logic [Q_WIDTH-1:0]  r_rem;      // the remainder is always < Q, so Q_WIDTH bits suffice
  logic [MU_WIDTH-1:0] r_quo;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err_nxt;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [MU_WIDTH-1:0] r_mu_out;
  logic [Q_WIDTH-1:0]  r_q_out;

  // Only the MSB of the dividend 2^K is set, so the bit shifted in is 1 on the first iteration only.
  logic                w_bit;
  logic [Q_WIDTH:0]    w_t;
  logic [Q_WIDTH:0]    w_diff;
  logic                w_ge;

  assign w_bit  = (r_cnt == CNT_W'(K));
  assign w_t    = {r_rem, w_bit};
  assign w_diff = w_t - {1'b0, r_q};
  // w_t <= 2Q-1, so w_t-Q lies in [-Q, Q-1]. That range fits Q_WIDTH+1 bits signed.
  // The MSB of the difference is therefore the borrow, and one subtractor does both compare and subtract.
  assign w_ge   = ~w_diff[Q_WIDTH];

  logic                w_hit;
  logic [MU_WIDTH-1:0] w_cache_mu;

`ifdef BARRETT_MU_CACHE_EN
  logic                r_cache_vld;
  logic [Q_WIDTH-1:0]  r_cache_q;
  logic [MU_WIDTH-1:0] r_cache_mu;

  assign w_hit      = r_cache_vld && (bus.Q == r_cache_q);
  assign w_cache_mu = r_cache_mu;

  // Capture only successful results. An err completion leaves the cache untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cache_vld <= 1'b0;
      r_cache_q   <= '0;
      r_cache_mu  <= '0;
    end else if (r_state == ST_FIN && !r_err_nxt) begin
      r_cache_vld <= 1'b1;
      r_cache_q   <= r_q;
      r_cache_mu  <= r_quo;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_cache_mu = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_q       <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_err_nxt <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_mu_out  <= '0;
      r_q_out   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_q <= bus.Q;
            if (bus.Q == '0) begin
              r_err_nxt <= 1'b1;
              r_quo     <= '1;
              r_state   <= ST_FIN;
            end else if (w_hit) begin
              r_err_nxt <= 1'b0;
              r_quo     <= w_cache_mu;
              r_state   <= ST_FIN;
            end else begin
              r_err_nxt <= 1'b0;
              r_rem     <= '0;
              r_quo     <= '0;
              r_cnt     <= CNT_W'(K);
              r_busy    <= 1'b1;
              r_state   <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          r_rem <= w_ge ? w_diff[Q_WIDTH-1:0] : w_t[Q_WIDTH-1:0];
          r_quo <= {r_quo[MU_WIDTH-2:0], w_ge};
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= ST_FIN;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_FIN: begin
          // r_quo already holds all-ones on the error path.
          r_mu_out <= r_quo;
          r_q_out  <= r_q;
          r_err    <= r_err_nxt;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.mu_out = r_mu_out;
  assign bus.q_out  = r_q_out;
endmodule
